// File: rtl/uart_pkg.sv
// uart_pkg: serializer states, register offsets and status bit positions shared by the UART TX block
package uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
    localparam logic [15:0] UART_DATA_OFS = 16'd0;
    localparam logic [15:0] UART_STAT_OFS = 16'd1;
    localparam int STAT_NOT_FULL = 0;
    localparam int STAT_IDLE     = 1;
    localparam int STAT_OVERFLOW = 7;
endpackage

// File: rtl/uart_tx_port_if.sv
// uart_tx_port_if: CPU6 bus bundle (address, write_en, data_in to the peripheral; data_out back to the CPU)
interface uart_tx_port_if;
    logic [15:0] address;
    logic        write_en;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    modport master (output address, write_en, data_in, input data_out);
    modport slave (input address, write_en, data_in, output data_out);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO; ports clock, reset, push/push_data, pop/pop_data (head, combinational), full, empty
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    // Pointers carry one extra wrap bit so full and empty are distinguishable
    assign empty    = wr_ptr == rd_ptr;
    assign full     = wr_ptr[AW-1:0] == rd_ptr[AW-1:0] && wr_ptr[AW] != rd_ptr[AW];
    assign pop_data = mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/uart_tx_port.sv
// uart_tx_port: CPU6-mapped 8N1 UART transmitter with TX FIFO
// Ports: clock, reset (sync, active high); bus (data reg at BASE_ADDR write-only,
// status at BASE_ADDR+1 = {overflow, 5'b0, idle, not_full}, write clears overflow); tx serial out, idle high.
module uart_tx_port
    import uart_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 434,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [15:0] BASE_ADDR    = 16'hF200
) (
    input  logic          clock,
    input  logic          reset,
    uart_tx_port_if.slave bus,
    output logic          tx
);
    localparam int BW = CLKS_PER_BIT > 2 ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    tx_state_t   state;
    logic [BW-1:0] baud;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift, head, status;
    logic        overflow, full, empty, pop, data_wr, stat_rd, stat_wr;
    assign data_wr = bus.write_en && bus.address == BASE_ADDR + UART_DATA_OFS;
    assign stat_rd = bus.address == BASE_ADDR + UART_STAT_OFS;
    assign stat_wr = bus.write_en && stat_rd;
    assign pop     = state == IDLE && !empty;
    always_comb begin
        status = '0;
        status[STAT_NOT_FULL] = !full;
        status[STAT_IDLE]     = state == IDLE && empty;
        status[STAT_OVERFLOW] = overflow;
    end
    assign bus.data_out = stat_rd ? status : 8'h00;
    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (data_wr),
        .push_data(bus.data_in),
        .pop      (pop),
        .pop_data (head),
        .full     (full),
        .empty    (empty)
    );
    // Overflow set beats a same-cycle clear; full is the pre-edge value so a concurrent pop does not save the byte
    always_ff @(posedge clock) begin
        if (reset) overflow <= 1'b0;
        else if (data_wr && full) overflow <= 1'b1;
        else if (stat_wr) overflow <= 1'b0;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            tx      <= 1'b1;
            baud    <= '0;
            bit_cnt <= '0;
            shift   <= 8'hFF;
        end else begin
            case (state)
                IDLE: begin
                    tx <= !pop;
                    if (pop) begin
                        shift   <= head;
                        bit_cnt <= '0;
                        baud    <= '0;
                        state   <= START;
                    end
                end
                START: begin
                    baud <= baud == BAUD_LAST ? '0 : baud + 1'b1;
                    if (baud == BAUD_LAST) begin
                        state <= DATA;
                        tx    <= shift[0];
                    end
                end
                DATA: begin
                    baud <= baud == BAUD_LAST ? '0 : baud + 1'b1;
                    // shift[1] is the next bit once this shift lands
                    if (baud == BAUD_LAST) begin
                        shift   <= {1'b1, shift[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        state   <= bit_cnt == 3'd7 ? STOP : DATA;
                        tx      <= bit_cnt == 3'd7 ? 1'b1 : shift[1];
                    end
                end
                default: begin
                    baud <= baud == BAUD_LAST ? '0 : baud + 1'b1;
                    if (baud == BAUD_LAST) state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_port.sv
// tb_uart_tx_port: randomized self-checking bench against a frame-timeline model of the UART transmitter
module tb_uart_tx_port;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic tx_a, tx_b;
    uart_tx_port_if bus_a ();
    uart_tx_port_if bus_b ();
    uart_tx_port #(.CLKS_PER_BIT(4), .FIFO_DEPTH(8), .BASE_ADDR(16'hF200)) dut_a (
        .clock(clock), .reset(reset), .bus(bus_a), .tx(tx_a));
    uart_tx_port #(.CLKS_PER_BIT(16), .FIFO_DEPTH(8), .BASE_ADDR(16'hF200)) dut_b (
        .clock(clock), .reset(reset), .bus(bus_b), .tx(tx_b));
    always #5 clock = ~clock;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    // Model of dut_a: each accepted byte has a push edge and a start edge; a frame lasts 40 cycles
    int fs[$];
    int fw[$];
    logic [7:0] fb[$];
    bit ovf_m = 1'b0;
    int last_start = -1000;
    logic hist_b[$];
    always @(negedge clock) hist_b.push_back(tx_b);

    function automatic logic exp_tx(int c);
        foreach (fs[i]) begin
            if (c >= fs[i] && c < fs[i] + 40) begin
                int o = (c - fs[i]) / 4;
                logic [7:0] b = fb[i];
                return o == 0 ? 1'b0 : o == 9 ? 1'b1 : b[o-1];
            end
        end
        return 1'b1;
    endfunction

    function automatic int pending(int c);
        int n = 0;
        foreach (fs[i]) if (fw[i] <= c && fs[i] > c) n++;
        return n;
    endfunction

    function automatic int occ_before(int e);
        int n = 0;
        foreach (fs[i]) if (fw[i] < e && fs[i] >= e) n++;
        return n;
    endfunction

    function automatic logic [7:0] exp_stat(int c);
        bit busy = 1'b0;
        foreach (fs[i]) if (c >= fs[i] && c < fs[i] + 40) busy = 1'b1;
        return {ovf_m, 5'b0, !busy && pending(c) == 0, pending(c) < 8};
    endfunction

    task automatic edge_a(input bit r, input bit w, input logic [15:0] a, input logic [7:0] d);
        int s;
        reset = r;
        bus_a.write_en = w;
        bus_a.address = a;
        bus_a.data_in = d;
        @(posedge clock);
        cyc++;
        if (r) begin
            fs.delete();
            fw.delete();
            fb.delete();
            ovf_m = 1'b0;
            last_start = -1000;
        end else if (w && a == 16'hF200) begin
            if (occ_before(cyc) >= 8) ovf_m = 1'b1;
            else begin
                s = cyc + 1 > last_start + 41 ? cyc + 1 : last_start + 41;
                fs.push_back(s);
                fw.push_back(cyc);
                fb.push_back(d);
                last_start = s;
            end
        end else if (w && a == 16'hF201) ovf_m = 1'b0;
        #1;
        reset = 1'b0;
        bus_a.write_en = 1'b0;
        bus_a.address = 16'hF201;
        #1;
        total++;
        if (tx_a !== exp_tx(cyc)) begin
            bad++;
            $display("FAIL tx cyc=%0d got=%b exp=%b", cyc, tx_a, exp_tx(cyc));
        end
        total++;
        if (bus_a.data_out !== exp_stat(cyc)) begin
            bad++;
            $display("FAIL status cyc=%0d got=%h exp=%h", cyc, bus_a.data_out, exp_stat(cyc));
        end
    endtask

    task automatic idle_a(input int n);
        for (int i = 0; i < n; i++) edge_a(1'b0, 1'b0, 16'hF201, 8'h00);
    endtask

    task automatic test_reset;
        edge_a(1'b1, 1'b1, 16'hF200, 8'hAA);
        edge_a(1'b1, 1'b1, 16'hF200, 8'h55);
        idle_a(6);
        total++;
        if (tx_a !== 1'b1 || bus_a.data_out !== 8'h03) begin
            bad++;
            $display("FAIL reset_state got tx=%b stat=%h exp tx=1 stat=03", tx_a, bus_a.data_out);
        end
    endtask

    task automatic test_frame;
        edge_a(1'b0, 1'b1, 16'hF200, 8'h48);
        idle_a(45);
    endtask

    task automatic test_back_to_back;
        logic obs[100];
        int s1 = -1;
        int s2 = -1;
        edge_a(1'b0, 1'b1, 16'hF200, 8'h41);
        obs[0] = tx_a;
        edge_a(1'b0, 1'b1, 16'hF200, 8'h42);
        obs[1] = tx_a;
        for (int i = 2; i < 100; i++) begin
            idle_a(1);
            obs[i] = tx_a;
        end
        for (int i = 0; i < 100; i++) if (obs[i] === 1'b0 && s1 < 0) s1 = i;
        for (int i = 0; i < 100; i++) if (obs[i] === 1'b0 && s1 >= 0 && i >= s1 + 40 && s2 < 0) s2 = i;
        total++;
        if (s1 != 1) begin
            bad++;
            $display("FAIL first_start got=%0d exp=1", s1);
        end
        total++;
        if (s2 - s1 != 41) begin
            bad++;
            $display("FAIL start_gap got=%0d exp=41", s2 - s1);
        end
    endtask

    task automatic test_random;
        for (int r = 0; r < 25; r++) begin
            int n = $urandom_range(1, 11);
            for (int i = 0; i < n; i++) begin
                int k = $urandom_range(0, 9);
                if (k == 0) edge_a(1'b0, 1'b1, 16'hF201, 8'($urandom));
                else if (k == 1) edge_a(1'b0, 1'b1, 16'($urandom), 8'($urandom));
                else edge_a(1'b0, 1'b1, 16'hF200, 8'($urandom));
            end
            idle_a($urandom_range(0, 300));
        end
        idle_a(500);
    endtask

    task automatic test_addr_decode;
        logic [15:0] addrs[6];
        addrs = '{16'hF200, 16'hF202, 16'h0000, 16'hF1FF, 16'hFFFF, 16'h0201};
        for (int i = 0; i < 6; i++) begin
            bus_a.address = addrs[i];
            #1;
            total++;
            if (bus_a.data_out !== 8'h00) begin
                bad++;
                $display("FAIL read_%h got=%h exp=00", addrs[i], bus_a.data_out);
            end
        end
        bus_a.address = 16'hF201;
        #1;
    endtask

    task automatic test_reset_mid;
        int s;
        edge_a(1'b0, 1'b1, 16'hF200, 8'hC5);
        s = cyc + 1;
        edge_a(1'b0, 1'b1, 16'hF200, 8'h3C);
        while (cyc < s + 16) idle_a(1);
        edge_a(1'b1, 1'b1, 16'hF200, 8'h11);
        total++;
        if (tx_a !== 1'b1 || bus_a.data_out !== 8'h03) begin
            bad++;
            $display("FAIL reset_mid got tx=%b stat=%h exp tx=1 stat=03", tx_a, bus_a.data_out);
        end
        idle_a(100);
    endtask

    task automatic test_overflow;
        logic [7:0] got[$];
        int i = 0;
        int stop_bad = 0;
        hist_b.delete();
        for (int k = 0; k < 10; k++) begin
            bus_b.address = 16'hF200;
            bus_b.write_en = 1'b1;
            bus_b.data_in = 8'(k);
            @(posedge clock);
            #1;
        end
        bus_b.write_en = 1'b0;
        bus_b.address = 16'hF201;
        #1;
        total++;
        if (bus_b.data_out !== 8'h80) begin
            bad++;
            $display("FAIL ovf_status got=%h exp=80", bus_b.data_out);
        end
        bus_b.write_en = 1'b1;
        @(posedge clock);
        #1;
        bus_b.write_en = 1'b0;
        #1;
        total++;
        if (bus_b.data_out !== 8'h00) begin
            bad++;
            $display("FAIL ovf_clear got=%h exp=00", bus_b.data_out);
        end
        repeat (10 * 161 + 100) @(posedge clock);
        #1;
        total++;
        if (bus_b.data_out !== 8'h03) begin
            bad++;
            $display("FAIL drained_status got=%h exp=03", bus_b.data_out);
        end
        while (i < hist_b.size()) begin
            if (hist_b[i] === 1'b0 && i + 152 < hist_b.size()) begin
                logic [7:0] b;
                for (int k = 0; k < 8; k++) b[k] = hist_b[i + 8 + 16 * (k + 1)];
                if (hist_b[i + 152] !== 1'b1) stop_bad++;
                got.push_back(b);
                i += 160;
            end else i++;
        end
        total++;
        if (got.size() != 9 || stop_bad != 0) begin
            bad++;
            $display("FAIL ovf_frames got=%0d stop_errs=%0d exp=9 stop_errs=0", got.size(), stop_bad);
        end
        for (int k = 0; k < 9 && k < got.size(); k++) begin
            total++;
            if (got[k] !== 8'(k)) begin
                bad++;
                $display("FAIL ovf_byte%0d got=%h exp=%h", k, got[k], 8'(k));
            end
        end
    endtask

    initial begin
        bus_a.address = 16'hF201;
        bus_a.write_en = 1'b0;
        bus_a.data_in = 8'h00;
        bus_b.address = 16'hF201;
        bus_b.write_en = 1'b0;
        bus_b.data_in = 8'h00;
        test_reset;
        test_frame;
        test_back_to_back;
        test_random;
        test_addr_decode;
        test_reset_mid;
        test_overflow;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
